// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: size encodings, FSM states and
// the helpers that decide whether a request may reach the bus.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'd0,
        SZ_HALF   = 2'd1,
        SZ_WORD   = 2'd2,
        SZ_DOUBLE = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_e;

    // A double access only exists on a 64-bit datapath.
    function automatic logic size_legal(input size_e size, input int xlen);
        return !(size == SZ_DOUBLE && xlen != 64);
    endfunction

    function automatic logic misaligned(input size_e size, input logic [2:0] addr_lo);
        case (size)
            SZ_HALF:   return addr_lo[0] != 1'b0;
            SZ_WORD:   return addr_lo[1:0] != 2'b00;
            SZ_DOUBLE: return addr_lo != 3'b000;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Bus side of mem_lsu: the LSU is the master, the memory is the slave.
interface mem_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              Bus_req;
    logic [ADDR_W-1:0] Bus_addr;
    logic              Bus_wen;
    logic [XLEN/8-1:0] Bus_wstrb;
    logic [XLEN-1:0]   Bus_wdata;
    logic              Bus_ack;
    logic [XLEN-1:0]   Bus_rdata;

    modport master (
        output Bus_req, Bus_addr, Bus_wen, Bus_wstrb, Bus_wdata,
        input  Bus_ack, Bus_rdata
    );

    modport slave (
        input  Bus_req, Bus_addr, Bus_wen, Bus_wstrb, Bus_wdata,
        output Bus_ack, Bus_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store strobes/replication and load
// extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  size_e                      size,
    input  logic [$clog2(XLEN/8)-1:0]  lane,
    input  logic                       is_unsigned,
    input  logic [XLEN-1:0]            wdata,
    input  logic [XLEN-1:0]            rdata,
    output logic [XLEN/8-1:0]          wstrb,
    output logic [XLEN-1:0]            wdata_rep,
    output logic [XLEN-1:0]            rdata_ext
);
    localparam int LANES = XLEN / 8;

    logic [LANES-1:0] size_mask;
    logic [XLEN-1:0]  val_mask;
    logic [XLEN-1:0]  shifted;
    logic             sign;

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        size_mask = '1;
        val_mask  = '1;
        wdata_rep = wdata;
        shifted   = rdata >> {lane, 3'b000};
        sign      = 1'b0;
        case (size)
            SZ_BYTE: begin
                size_mask = LANES'(1);
                val_mask  = XLEN'(8'hFF);
                wdata_rep = {LANES{wdata[7:0]}};
                sign      = shifted[7];
            end
            SZ_HALF: begin
                size_mask = LANES'(3);
                val_mask  = XLEN'(16'hFFFF);
                wdata_rep = {(XLEN/16){wdata[15:0]}};
                sign      = shifted[15];
            end
            SZ_WORD: begin
                size_mask = LANES'(15);
                val_mask  = XLEN'(32'hFFFF_FFFF);
                wdata_rep = {(XLEN/32){wdata[31:0]}};
                sign      = shifted[31];
            end
            default: ;
        endcase
        wstrb     = size_mask << lane;
        rdata_ext = (shifted & val_mask) | ((sign && !is_unsigned) ? ~val_mask : '0);
    end

endmodule

// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit bridging a CPU request port to a simple
// ack-based bus. Optional bus-wait abort is enabled with LSU_TIMEOUT_EN.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    mem_lsu_if.master         bus
);
    localparam int LANES  = XLEN / 8;
    localparam int LANE_W = $clog2(LANES);

    state_e            state, state_next;
    size_e             size_q, size_sel;
    logic              we_q, uns_q, uns_sel;
    logic [LANE_W-1:0] lane_q, lane_sel;
    logic              accept, req_bad, timeout;
    logic [LANES-1:0]  strb_c;
    logic [XLEN-1:0]   wdata_c, rdata_c;

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign accept     = req_valid && req_ready;
    assign req_bad    = !size_legal(size_e'(req_size), XLEN)
                     || misaligned(size_e'(req_size), req_addr[2:0]);

    // The aligner sees the live request while idle and the latched one afterwards.
    assign size_sel = req_ready ? size_e'(req_size) : size_q;
    assign lane_sel = req_ready ? req_addr[LANE_W-1:0] : lane_q;
    assign uns_sel  = req_ready ? req_unsigned : uns_q;

    lsu_align #(.XLEN(XLEN)) u_align (
        .size        (size_sel),
        .lane        (lane_sel),
        .is_unsigned (uns_sel),
        .wdata       (req_wdata),
        .rdata       (bus.Bus_rdata),
        .wstrb       (strb_c),
        .wdata_rep   (wdata_c),
        .rdata_ext   (rdata_c)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst)               tmo_cnt <= '0;
        else if (state != ST_BUS)  tmo_cnt <= '0;
        else                       tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign timeout = (state == ST_BUS) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = req_bad ? ST_RESP : ST_BUS;
            ST_BUS:  if (bus.Bus_ack || timeout) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            bus.Bus_req   <= 1'b0;
            bus.Bus_addr  <= '0;
            bus.Bus_wen   <= 1'b0;
            bus.Bus_wstrb <= '0;
            bus.Bus_wdata <= '0;
            resp_err      <= 1'b0;
            resp_rdata    <= '0;
            size_q        <= SZ_BYTE;
            we_q          <= 1'b0;
            uns_q         <= 1'b0;
            lane_q        <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    size_q     <= size_e'(req_size);
                    we_q       <= req_we;
                    uns_q      <= req_unsigned;
                    lane_q     <= req_addr[LANE_W-1:0];
                    resp_err   <= req_bad;
                    resp_rdata <= '0;
                    if (!req_bad) begin
                        bus.Bus_req   <= 1'b1;
                        bus.Bus_addr  <= {req_addr[ADDR_W-1:LANE_W], LANE_W'(0)};
                        bus.Bus_wen   <= req_we;
                        bus.Bus_wstrb <= req_we ? strb_c : '0;
                        bus.Bus_wdata <= wdata_c;
                    end
                end
                ST_BUS: if (bus.Bus_ack || timeout) begin
                    // An ack arriving on the timeout edge still completes normally.
                    bus.Bus_req   <= 1'b0;
                    bus.Bus_wen   <= 1'b0;
                    bus.Bus_wstrb <= '0;
                    resp_err      <= !bus.Bus_ack;
                    resp_rdata    <= (bus.Bus_ack && !we_q) ? rdata_c : '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: a 32-bit and a 64-bit instance share the
// request inputs; sel64 chooses which one is exercised and observed.
module tb_mem_lsu;

    logic        clk, rst, sel64;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        ack;
    logic [63:0] brdata;

    logic        rdy32, rv32, er32, rdy64, rv64, er64;
    logic [31:0] rd32;
    logic [63:0] rd64;

    int errors = 0;
    int checks = 0;

    mem_lsu_if #(.XLEN(32), .ADDR_W(32)) bus32();
    mem_lsu_if #(.XLEN(64), .ADDR_W(32)) bus64();

    assign bus32.Bus_ack   = ack & ~sel64;
    assign bus32.Bus_rdata = brdata[31:0];
    assign bus64.Bus_ack   = ack & sel64;
    assign bus64.Bus_rdata = brdata;

    mem_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut32 (
        .cpu_clk(clk), .cpu_rst(rst), .req_valid(req_valid & ~sel64), .req_ready(rdy32),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .resp_valid(rv32), .resp_rdata(rd32), .resp_err(er32), .bus(bus32)
    );

    mem_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut64 (
        .cpu_clk(clk), .cpu_rst(rst), .req_valid(req_valid & sel64), .req_ready(rdy64),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv64), .resp_rdata(rd64), .resp_err(er64), .bus(bus64)
    );

    logic        m_ready, m_rvalid, m_err, m_breq, m_bwen;
    logic [63:0] m_rdata, m_bwdata;
    logic [31:0] m_baddr;
    logic [7:0]  m_bstrb;

    assign m_ready  = sel64 ? rdy64 : rdy32;
    assign m_rvalid = sel64 ? rv64  : rv32;
    assign m_err    = sel64 ? er64  : er32;
    assign m_rdata  = sel64 ? rd64  : {32'b0, rd32};
    assign m_breq   = sel64 ? bus64.Bus_req   : bus32.Bus_req;
    assign m_bwen   = sel64 ? bus64.Bus_wen   : bus32.Bus_wen;
    assign m_baddr  = sel64 ? bus64.Bus_addr  : bus32.Bus_addr;
    assign m_bstrb  = sel64 ? bus64.Bus_wstrb : {4'b0, bus32.Bus_wstrb};
    assign m_bwdata = sel64 ? bus64.Bus_wdata : {32'b0, bus32.Bus_wdata};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: byte lanes, replication and extension from plain arithmetic.
    function automatic logic [63:0] model_strb(input int nb, input int off);
        return ((64'd1 << nb) - 64'd1) << off;
    endfunction

    function automatic logic [63:0] model_wdata(input int nb, input int xb, input logic [63:0] d);
        logic [63:0] r = '0;
        for (int i = 0; i < xb; i++) r[i*8 +: 8] = d[(i % nb)*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] model_load(input int nb, input int off, input logic uns,
                                               input logic [63:0] d);
        logic [63:0] mask, v;
        mask = (nb == 8) ? '1 : (64'd1 << (nb*8)) - 64'd1;
        v = (d >> (off*8)) & mask;
        if (!uns && v[nb*8-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [63:0] wdata,
                          input logic [63:0] brd, input int dly, input string tag);
        int nb, xb, off;
        logic bad;
        logic [63:0] xmask, e_strb, e_wdata, e_rdata;
        logic [31:0] e_addr;
        xb     = sel64 ? 8 : 4;
        nb     = 1 << size;
        off    = int'(addr % xb);
        xmask  = sel64 ? '1 : 64'h0000_0000_FFFF_FFFF;
        bad    = (nb > xb) || (addr % nb != 0);
        e_addr = addr & ~32'(xb - 1);
        e_strb = we ? model_strb(nb, off) : '0;
        e_wdata = model_wdata(nb, xb, wdata);
        e_rdata = (we || bad) ? '0 : (model_load(nb, off, uns, brd & xmask) & xmask);

        @(negedge clk);
        checks++;
        if (m_ready !== 1'b1) begin errors++; $display("FAIL %s ready: got %b want 1", tag, m_ready); end
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;

        if (!bad) begin
            for (int c = 0; c <= dly; c++) begin
                @(negedge clk);
                checks++;
                if ({m_breq, m_bwen, m_baddr, m_bstrb, m_rvalid} !== {1'b1, we, e_addr, e_strb[7:0], 1'b0}) begin
                    errors++;
                    $display("FAIL %s bus c%0d: got req=%b wen=%b addr=%h strb=%h rv=%b want 1 %b %h %h 0",
                             tag, c, m_breq, m_bwen, m_baddr, m_bstrb, m_rvalid, we, e_addr, e_strb[7:0]);
                end
                if (we) begin
                    checks++;
                    if (m_bwdata !== e_wdata) begin errors++; $display("FAIL %s wdata: got %h want %h", tag, m_bwdata, e_wdata); end
                end
                if (c == dly) begin ack = 1'b1; brdata = brd; end
            end
            @(posedge clk);
            #1 ack = 1'b0; brdata = {$urandom, $urandom};
        end

        @(negedge clk);
        checks++;
        if ({m_rvalid, m_err, m_breq} !== {1'b1, bad, 1'b0}) begin
            errors++;
            $display("FAIL %s resp: got rv=%b err=%b req=%b want 1 %b 0", tag, m_rvalid, m_err, m_breq, bad);
        end
        checks++;
        if (m_rdata !== e_rdata) begin errors++; $display("FAIL %s rdata: got %h want %h", tag, m_rdata, e_rdata); end
        @(negedge clk);
        checks++;
        if ({m_rvalid, m_ready} !== 2'b01) begin
            errors++;
            $display("FAIL %s after-resp: got rv=%b rdy=%b want 0 1", tag, m_rvalid, m_ready);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rdy32, rdy64} !== 2'b11) begin errors++; $display("FAIL reset ready: got %b want 11", {rdy32, rdy64}); end
        checks++;
        if ({rv32, er32, bus32.Bus_req, bus32.Bus_wen, bus32.Bus_wstrb, bus32.Bus_addr, bus32.Bus_wdata, rd32} !== '0) begin
            errors++; $display("FAIL reset dut32 outputs: got nonzero want 0");
        end
        checks++;
        if ({rv64, er64, bus64.Bus_req, bus64.Bus_wen, bus64.Bus_wstrb, bus64.Bus_addr, bus64.Bus_wdata, rd64} !== '0) begin
            errors++; $display("FAIL reset dut64 outputs: got nonzero want 0");
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_byte();
        sel64 = 1'b0;
        access(1'b1, 2'd0, 1'b0, 32'h1003, 64'hAB, 64'h0, 0, "sb_1003");
        access(1'b1, 2'd1, 1'b0, 32'h1006, 64'h1234, 64'h0, 1, "sh_1006");
    endtask

    task automatic test_load_half();
        sel64 = 1'b0;
        access(1'b0, 2'd1, 1'b0, 32'h2002, 64'h0, 64'h8001_0000, 0, "lh_signed");
        access(1'b0, 2'd1, 1'b1, 32'h2002, 64'h0, 64'h8001_0000, 2, "lhu");
        access(1'b0, 2'd0, 1'b0, 32'h2001, 64'h0, 64'h0000_F700, 0, "lb_signed");
    endtask

    task automatic test_errors();
        sel64 = 1'b0;
        access(1'b0, 2'd2, 1'b0, 32'h3001, 64'h0, 64'h0, 0, "lw_misaligned");
        access(1'b1, 2'd1, 1'b0, 32'h3003, 64'h55, 64'h0, 0, "sh_misaligned");
        access(1'b0, 2'd3, 1'b0, 32'h3000, 64'h0, 64'h0, 0, "ld_on_32");
        sel64 = 1'b1;
        access(1'b0, 2'd3, 1'b0, 32'h3004, 64'h0, 64'h0, 0, "ld_misaligned_64");
    endtask

    task automatic test_double64();
        sel64 = 1'b1;
        access(1'b0, 2'd3, 1'b0, 32'h08, 64'h0, 64'hFEDC_BA98_7654_3210, 0, "ld_08");
        access(1'b1, 2'd3, 1'b0, 32'h10, 64'h0123_4567_89AB_CDEF, 64'h0, 1, "sd_10");
        access(1'b0, 2'd2, 1'b0, 32'h0C, 64'h0, 64'h8000_0001_0000_0000, 0, "lw_hi_64");
    endtask

    task automatic test_stray_ack();
        int seen = 0;
        sel64 = 1'b0;
        @(negedge clk);
        ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (m_rvalid !== 1'b0 || m_breq !== 1'b0 || m_ready !== 1'b1) seen++;
        end
        ack = 1'b0;
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL stray_ack: got %0d reacting cycles want 0", seen); end
    endtask

    task automatic test_timeout();
        int n = 0;
        sel64 = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h4000;
        @(posedge clk);
        #1 req_valid = 1'b0;
`ifdef LSU_TIMEOUT_EN
        @(negedge clk);
        while (m_breq === 1'b1 && n < 50) begin n++; @(negedge clk); end
        checks++;
        if (n !== 4) begin errors++; $display("FAIL timeout bus_req cycles: got %0d want 4", n); end
        checks++;
        if ({m_rvalid, m_err, m_rdata} !== {2'b11, 64'h0}) begin
            errors++; $display("FAIL timeout resp: got rv=%b err=%b rdata=%h want 1 1 0", m_rvalid, m_err, m_rdata);
        end
        @(negedge clk);
`else
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (m_breq !== 1'b1 || m_rvalid !== 1'b0) n++;
        end
        checks++;
        if (n !== 0) begin errors++; $display("FAIL no_timeout wait: got %0d idle cycles want 0", n); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
    endtask

    task automatic test_reset_mid_bus();
        int seen = 0;
        sel64 = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h5000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_breq !== 1'b1) begin errors++; $display("FAIL rst_mid pre: got req=%b want 1", m_breq); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({m_breq, m_ready} !== 2'b01) begin
            errors++; $display("FAIL rst_mid async: got req=%b rdy=%b want 0 1", m_breq, m_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (m_rvalid !== 1'b0 || m_breq !== 1'b0 || m_ready !== 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL rst_mid after: got %0d bad cycles want 0", seen); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            int          nb;
            sel64 = i[0];
            sz = 2'($urandom_range(0, 3));
            nb = 1 << sz;
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nb - 1);
            access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                   {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 3)),
                   $sformatf("rnd%0d", i));
        end
    endtask

    initial begin
        rst = 1'b0; sel64 = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; ack = 1'b0; brdata = '0;
        test_reset();
        test_store_byte();
        test_load_half();
        test_errors();
        test_double64();
        test_stray_ack();
        test_timeout();
        test_reset_mid_bus();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter XLEN, default 32, data/bus width; legal values 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, bus-wait limit; used only when LSU_TIMEOUT_EN is defined.
REQ-004 cpu_clk  in  1  single clock; all state changes on rising edge.
REQ-005 cpu_rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  1  access request.
REQ-007 req_ready  out  1  request accepted when req_valid and req_ready are both high at an edge.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
REQ-010 req_unsigned  in  1  zero-extend load result.
REQ-011 req_addr  in  ADDR_W  byte address.
REQ-012 req_wdata  in  XLEN  store data, right-aligned.
REQ-013 resp_valid  out  1  one-cycle completion pulse.
REQ-014 resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
REQ-015 resp_err  out  1  misaligned, illegal size or timeout; valid with resp_valid.
REQ-016 Bus_req  out  1  bus cycle active.
REQ-017 Bus_addr  out  ADDR_W  aligned address, low log2(XLEN/8) bits zero.
REQ-018 Bus_wen  out  1  write enable, qualified by Bus_req.
REQ-019 Bus_wstrb  out  XLEN/8  byte-lane strobes.
REQ-020 Bus_wdata  out  XLEN  lane-replicated store data.
REQ-021 Bus_ack  in  1  bus completes the current cycle.
REQ-022 Bus_rdata  in  XLEN  read data, valid with Bus_ack.

Function
REQ-023 The FSM SHALL have states IDLE, BUS and RESP; req_ready = 1 only in IDLE.
REQ-024 On acceptance, the request SHALL be registered: legal aligned -> BUS; misaligned or illegal size -> RESP with error flag set and no bus cycle.
REQ-025 Misaligned means half with addr[0]!=0, word with addr[1:0]!=0, double with addr[2:0]!=0; size 3 with XLEN=32 is illegal.
REQ-026 In BUS, Bus_req and the Bus_* outputs SHALL be driven from registers and held stable until Bus_ack is sampled high.
REQ-027 An edge with Bus_ack high in BUS SHALL capture Bus_rdata and go to RESP; minimum latency is acceptance edge k, Bus_req high in cycle k+1, resp_valid in cycle k+2.
REQ-028 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE; a new request is accepted no earlier than the following edge.
REQ-029 Store lanes: Bus_wstrb SHALL set size-many bits starting at the lane given by the low address bits; Bus_wdata SHALL replicate the byte/half/word across all lanes.
REQ-030 Load extraction: the selected lanes SHALL be shifted to bit 0 and extended by sign (bit 7/15/31) unless req_unsigned is set.
REQ-031 Bus_ack outside BUS SHALL be ignored.
REQ-032 req_valid while not ready SHALL be ignored; the requester holds the request.

Reset
REQ-033 Assertion of cpu_rst SHALL immediately force IDLE, req_ready=1, and resp_valid, resp_err, Bus_req, Bus_wen and Bus_wstrb to 0; Bus_addr, Bus_wdata and resp_rdata to 0.
REQ-034 Reset during BUS SHALL abandon the bus cycle with no response.

Configuration
REQ-035 With LSU_TIMEOUT_EN defined, a counter cleared on entry to BUS SHALL abort the cycle after TIMEOUT_CYCLES cycles without Bus_ack: drop Bus_req and go to RESP with resp_err=1 and resp_rdata=0.
REQ-036 Without LSU_TIMEOUT_EN, there SHALL be no counter and BUS SHALL wait indefinitely.

Structure
REQ-037 Package lsu_pkg SHALL hold the size encodings, the state enum and the XLEN legality check.
REQ-038 Lane steering and extension SHALL live in the combinational sub-module lsu_align.

Verification
REQ-039 SB at 0x1003 with wdata 0xAB, ack 1 cycle later -> Bus_addr 0x1000, wstrb 4'b1000, wdata 0xABABABAB; resp_valid at k+2 with err 0.
REQ-040 LH at 0x2002 with Bus_rdata 0x8001_0000 -> resp_rdata 0xFFFF8001; with req_unsigned -> 0x00008001.
REQ-041 LW at 0x3001 -> no Bus_req; resp_valid at k+1 with err 1 and rdata 0.
REQ-042 LW with ack withheld, LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4 -> Bus_req for 4 cycles, then resp_err=1; without the macro, still waiting after 1000 cycles.
REQ-043 cpu_rst pulsed mid-BUS -> Bus_req 0 asynchronously, no resp_valid, req_ready 1 after release.
REQ-044 XLEN=64, double load at 0x08 -> wstrb 8'h00 and full 64-bit rdata; size 3 with XLEN=32 -> err.
